// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - ID-stage front end: IF/ID register, inst hold, GPR file, operand forwarding
module id_operand_stage #(
  parameter int                 DATA_W        = 32,
  parameter int                 NUM_FWD       = 3,
  parameter logic [NUM_FWD-1:0] FWD_LOAD_MASK = 3'b001,
  parameter int                 STALL_W       = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      flush,
  input  logic                      if_ce,
  input  logic [31:0]               if_pc,
  input  logic [31:0]               inst_sram_rdata,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*5-1:0]      fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic                      wb_we,
  input  logic [4:0]                wb_waddr,
  input  logic [DATA_W-1:0]         wb_wdata,
  output logic                      id_valid,
  output logic [31:0]               id_pc,
  output logic [31:0]               id_inst,
  output logic [DATA_W-1:0]         rdata1,
  output logic [DATA_W-1:0]         rdata2,
  output logic                      stallreq
);

  localparam logic [0:0] ST_PASS = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]        state;
  logic [31:0]       inst_hold;
  logic [DATA_W-1:0] gpr [32];

  logic              stall_ifid;
  logic              stall_id;
  logic              unused_stall;

  assign stall_ifid   = stall[1];
  assign stall_id     = stall[2];
  assign unused_stall = ^{stall[STALL_W-1:3], stall[0]};

  // IF/ID pipeline register: flush beats bubble beats load beats hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid <= 1'b0;
      id_pc    <= 32'h0;
    end else if (flush || (stall_ifid && !stall_id)) begin
      id_valid <= 1'b0;
      id_pc    <= 32'h0;
    end else if (!stall_ifid) begin
      id_valid <= if_ce;
      id_pc    <= if_pc;
    end
  end

  // The SRAM word is only valid the cycle after fetch, so an ID stall must capture it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_PASS;
      inst_hold <= 32'h0;
    end else begin
      case (state)
        ST_PASS: begin
          if (stall_id && !flush) begin
            inst_hold <= inst_sram_rdata;
            state     <= ST_HOLD;
          end
        end
        default: begin
          if (!stall_id || flush) state <= ST_PASS;
        end
      endcase
    end
  end

  always_comb begin
    id_inst = 32'h0;
    if (id_valid) id_inst = (state == ST_HOLD) ? inst_hold : inst_sram_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (wb_we && wb_waddr != 5'd0) begin
      gpr[wb_waddr] <= wb_wdata;
    end
  end

  function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] addr);
    if (addr == 5'd0)                    return '0;
    else if (wb_we && wb_waddr == addr) return wb_wdata;
    else                                 return gpr[addr];
  endfunction

  // Returns {stall, value}; scanning high to low lets the lowest-index match win
  function automatic logic [DATA_W:0] resolve(input logic [4:0] addr);
    logic [DATA_W-1:0] val;
    logic              ld;
    val = rf_read(addr);
    ld  = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && fwd_waddr[5*i +: 5] == addr) begin
        val = fwd_wdata[DATA_W*i +: DATA_W];
        ld  = FWD_LOAD_MASK[i] & fwd_is_load[i];
      end
    end
    if (addr == 5'd0) begin
      val = '0;
      ld  = 1'b0;
    end
    return {ld, val};
  endfunction

  logic [4:0]      rs_addr;
  logic [4:0]      rt_addr;
  logic [DATA_W:0] rs_res;
  logic [DATA_W:0] rt_res;

  assign rs_addr = id_inst[25:21];
  assign rt_addr = id_inst[20:16];

  always_comb begin
    rs_res = resolve(rs_addr);
    rt_res = resolve(rt_addr);
  end

  assign rdata1   = rs_res[DATA_W-1:0];
  assign rdata2   = rt_res[DATA_W-1:0];
  assign stallreq = id_valid & (rs_res[DATA_W] | rt_res[DATA_W]);

endmodule
